// File: rtl/scarv_cop_idq.sv
//-----------------------------------------------------------------------------
// scarv_cop_idq
//
// Purpose:
//   Registered decoded-instruction queue sitting between the CPU-side
//   instruction port and the coprocessor execute stage. Each accepted 32-bit
//   ISE encoding is stored together with the upstream decoder's class,
//   subclass and pack-width outputs, an exception code and a wrapping tag.
//   The MCCR feature-enable switches are applied here, at decode time: an
//   instruction whose feature is switched off is still queued, in order, but
//   carries q_exc = 2.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   PTR_W  log2(DEPTH)
//   TAG_W  width of the wrapping instruction tag counter
//
// Ports:
//   g_clk, g_resetn   clock, asynchronous active-low reset
//   cpu_insn_req/ack  CPU-side valid/ready; ack = !full && !flush
//   cpu_insn_enc      raw 32-bit encoding
//   dec_*             upstream decoder results for cpu_insn_enc
//   mccr              feature enables {P2,P4,P8,P16,P32,SG,MP,R} (bit7..0)
//   flush             discard every queued entry at the next clock edge
//   q_valid/q_ready   execute-side valid/ready for the head entry
//   q_enc .. q_tag    head entry fields (hold last head while q_valid = 0)
//   q_exc             0 none, 1 illegal, 2 feature disabled
//   q_level           occupancy, 0..DEPTH
//
// Optional feature:
//   SCARV_COP_IDQ_BYPASS_EN - when defined, an instruction arriving at an
//   empty, non-flushing queue while q_ready is high is passed straight to
//   the q_* outputs in the same cycle and never written to storage. When
//   undefined the minimum latency through the queue is one cycle.
//
// Encodings used for the feature checks:
//   classes    PACKED_ARITH=1, LOADSTORE=3, RANDOM=4, MP=6
//   subclasses SCATTER_B=1, SCATTER_H=2, GATHER_B=3, GATHER_H=4
//   pack width PW_1=1, PW_2=2, PW_4=3, PW_8=4, PW_16=5
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module scarv_cop_idq #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int TAG_W = 4
) (
    input  logic               g_clk,
    input  logic               g_resetn,

    input  logic               cpu_insn_req,
    output logic               cpu_insn_ack,
    input  logic [31:0]        cpu_insn_enc,

    input  logic               dec_exception,
    input  logic [3:0]         dec_class,
    input  logic [4:0]         dec_subclass,
    input  logic [2:0]         dec_pw,

    input  logic [7:0]         mccr,
    input  logic               flush,

    output logic               q_valid,
    input  logic               q_ready,
    output logic [31:0]        q_enc,
    output logic [3:0]         q_class,
    output logic [4:0]         q_subclass,
    output logic [2:0]         q_pw,
    output logic [1:0]         q_exc,
    output logic [TAG_W-1:0]   q_tag,
    output logic [PTR_W:0]     q_level
);

    // Instruction class codes
    localparam logic [3:0] ICLASS_PACKED_ARITH = 4'd1;
    localparam logic [3:0] ICLASS_LOADSTORE    = 4'd3;
    localparam logic [3:0] ICLASS_RANDOM       = 4'd4;
    localparam logic [3:0] ICLASS_MP           = 4'd6;

    // Load/store scatter-gather subclasses
    localparam logic [4:0] SCLASS_SCATTER_B    = 5'd1;
    localparam logic [4:0] SCLASS_SCATTER_H    = 5'd2;
    localparam logic [4:0] SCLASS_GATHER_B     = 5'd3;
    localparam logic [4:0] SCLASS_GATHER_H     = 5'd4;

    // Pack widths
    localparam logic [2:0] PW_1  = 3'd1;
    localparam logic [2:0] PW_2  = 3'd2;
    localparam logic [2:0] PW_4  = 3'd3;
    localparam logic [2:0] PW_8  = 3'd4;
    localparam logic [2:0] PW_16 = 3'd5;

    // MCCR bit positions
    localparam int MCCR_R   = 0;
    localparam int MCCR_MP  = 1;
    localparam int MCCR_SG  = 2;
    localparam int MCCR_P32 = 3;
    localparam int MCCR_P16 = 4;
    localparam int MCCR_P8  = 5;
    localparam int MCCR_P4  = 6;
    localparam int MCCR_P2  = 7;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
    localparam logic [1:0] EXC_FEATURE  = 2'd2;

    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]      enc;
        logic [3:0]       cls;
        logic [4:0]       sub;
        logic [2:0]       pw;
        logic [1:0]       exc;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q,  level_d;
    logic [TAG_W-1:0] tag_q,    tag_d;
    entry_t           head_q,   head_d;
    // Holds ack low until the first clock after reset is released.
    logic             rst_done_q;

    entry_t           store_q [DEPTH];

    // ------------------------------------------------------------------
    // Feature-enable check on the incoming instruction
    // ------------------------------------------------------------------
    logic   feat_ok;
    logic   is_sg;
    logic [1:0] new_exc;
    entry_t in_entry;

    assign is_sg = (dec_subclass == SCLASS_SCATTER_B) ||
                   (dec_subclass == SCLASS_SCATTER_H) ||
                   (dec_subclass == SCLASS_GATHER_B)  ||
                   (dec_subclass == SCLASS_GATHER_H);

    always_comb begin
        feat_ok = 1'b1;
        case (dec_class)
            ICLASS_RANDOM:    feat_ok = mccr[MCCR_R];
            ICLASS_MP:        feat_ok = mccr[MCCR_MP];
            ICLASS_LOADSTORE: begin
                if (is_sg) begin
                    feat_ok = mccr[MCCR_SG];
                end
            end
            ICLASS_PACKED_ARITH: begin
                // Narrower element width means more lanes: PW_1 is the
                // 32-lane form, PW_16 the 2-lane form.
                case (dec_pw)
                    PW_1:    feat_ok = mccr[MCCR_P32];
                    PW_2:    feat_ok = mccr[MCCR_P16];
                    PW_4:    feat_ok = mccr[MCCR_P8];
                    PW_8:    feat_ok = mccr[MCCR_P4];
                    PW_16:   feat_ok = mccr[MCCR_P2];
                    default: feat_ok = 1'b1;
                endcase
            end
            default:          feat_ok = 1'b1;
        endcase
    end

    // An upstream decode exception takes precedence over a disabled feature.
    assign new_exc = dec_exception ? EXC_ILLEGAL :
                     (!feat_ok     ? EXC_FEATURE : EXC_NONE);

    assign in_entry = '{enc: cpu_insn_enc,
                        cls: dec_class,
                        sub: dec_subclass,
                        pw:  dec_pw,
                        exc: new_exc,
                        tag: tag_q};

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic push_req;
    logic push;
    logic pop;
    logic bypass;

    assign full         = (level_q == LEVEL_FULL);
    assign empty        = (level_q == '0);
    assign cpu_insn_ack = rst_done_q && !full && !flush;
    assign push_req     = cpu_insn_req && cpu_insn_ack;

`ifdef SCARV_COP_IDQ_BYPASS_EN
    // ack already excludes flush, so push_req implies no flush here.
    assign bypass = push_req && empty && q_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction is consumed directly and never stored.
    assign push = push_req && !bypass;
    // A pop in the flush cycle is irrelevant: the whole queue goes anyway.
    assign pop  = !empty && q_ready && !flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        tag_d    = tag_q;
        head_d   = head_q;

        // Every accepted instruction consumes a tag, bypassed or not.
        if (push_req) begin
            tag_d = tag_q + TAG_W'(1);
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + (PTR_W+1)'(1);
                2'b01:   level_d = level_q - (PTR_W+1)'(1);
                default: level_d = level_q;
            endcase
        end

        // The head register is a registered read of the next head slot.
        // When that slot is the one being written this cycle, the incoming
        // entry is forwarded so it appears at the head one cycle after push.
        // With an empty queue next cycle the head simply holds.
        if (bypass) begin
            head_d = in_entry;
        end else if (!flush && (level_d != '0)) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = in_entry;
            end else begin
                head_d = store_q[rd_ptr_d];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tag_q      <= '0;
            head_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tag_q      <= tag_d;
            head_q     <= head_d;
            rst_done_q <= 1'b1;
        end
    end

    // Storage has no reset: its contents are only ever read behind the
    // pointers, which are reset.
    always_ff @(posedge g_clk) begin
        if (push) begin
            store_q[wr_ptr_q] <= in_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    entry_t out_head;

    assign out_head   = bypass ? in_entry : head_q;
    assign q_valid    = !empty || bypass;
    assign q_enc      = out_head.enc;
    assign q_class    = out_head.cls;
    assign q_subclass = out_head.sub;
    assign q_pw       = out_head.pw;
    assign q_exc      = out_head.exc;
    assign q_tag      = out_head.tag;
    assign q_level    = level_q;

endmodule

// File: tb/tb_scarv_cop_idq.sv
`timescale 1ns/1ps

module tb_scarv_cop_idq;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int TAG_W = 4;

    localparam logic [3:0] C_PACKED    = 4'd1;
    localparam logic [3:0] C_LOADSTORE = 4'd3;
    localparam logic [3:0] C_RANDOM    = 4'd4;
    localparam logic [3:0] C_MOVE      = 4'd5;
    localparam logic [3:0] C_MP        = 4'd6;
    localparam logic [2:0] PW16        = 3'd5;

    logic               g_clk = 1'b0;
    logic               g_resetn = 1'b0;
    logic               cpu_insn_req = 1'b0;
    logic               cpu_insn_ack;
    logic [31:0]        cpu_insn_enc = '0;
    logic               dec_exception = 1'b0;
    logic [3:0]         dec_class = '0;
    logic [4:0]         dec_subclass = '0;
    logic [2:0]         dec_pw = '0;
    logic [7:0]         mccr = '0;
    logic               flush = 1'b0;
    logic               q_valid;
    logic               q_ready = 1'b0;
    logic [31:0]        q_enc;
    logic [3:0]         q_class;
    logic [4:0]         q_subclass;
    logic [2:0]         q_pw;
    logic [1:0]         q_exc;
    logic [TAG_W-1:0]   q_tag;
    logic [PTR_W:0]     q_level;

    scarv_cop_idq #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(TAG_W)) dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .cpu_insn_req  (cpu_insn_req),
        .cpu_insn_ack  (cpu_insn_ack),
        .cpu_insn_enc  (cpu_insn_enc),
        .dec_exception (dec_exception),
        .dec_class     (dec_class),
        .dec_subclass  (dec_subclass),
        .dec_pw        (dec_pw),
        .mccr          (mccr),
        .flush         (flush),
        .q_valid       (q_valid),
        .q_ready       (q_ready),
        .q_enc         (q_enc),
        .q_class       (q_class),
        .q_subclass    (q_subclass),
        .q_pw          (q_pw),
        .q_exc         (q_exc),
        .q_tag         (q_tag),
        .q_level       (q_level)
    );

    always #5 g_clk = ~g_clk;

    // Reference model: an ordered list of entries, a tag counter and the
    // most recent head value (what the outputs show while idle).
    typedef struct {
        logic [31:0] enc;
        logic [3:0]  cls;
        logic [4:0]  sub;
        logic [2:0]  pw;
        logic [1:0]  exc;
        int          tag;
    } ent_t;

    ent_t mq[$];
    ent_t last;
    int   m_tag;
    int   tests = 0;
    int   fails = 0;

    // Exception code from the feature rules: find which MCCR bit (if any)
    // the instruction needs and test it.
    function automatic logic [1:0] ref_exc(logic e, logic [3:0] c, logic [4:0] s,
                                           logic [2:0] pw, logic [7:0] m);
        int need;
        need = -1;
        if (e) return 2'd1;
        if (c == C_RANDOM)                                    need = 0;
        else if (c == C_MP)                                   need = 1;
        else if (c == C_LOADSTORE && s >= 5'd1 && s <= 5'd4) need = 2;
        else if (c == C_PACKED && pw >= 3'd1 && pw <= 3'd5)   need = 2 + int'(pw);
        if (need >= 0 && !m[need]) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(logic req, logic [3:0] c, logic [4:0] s, logic [2:0] p,
                          logic e, logic [7:0] m, logic rdy, logic fl);
        cpu_insn_req  = req;
        cpu_insn_enc  = $urandom;
        dec_class     = c;
        dec_subclass  = s;
        dec_pw        = p;
        dec_exception = e;
        mccr          = m;
        q_ready       = rdy;
        flush         = fl;
    endtask

    function automatic logic byp_now();
`ifdef SCARV_COP_IDQ_BYPASS_EN
        return cpu_insn_req && q_ready && !flush && (mq.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_state();
        logic bn;
        bn = byp_now();
        chk("level", 32'(q_level), mq.size());
        chk("valid", 32'(q_valid), 32'((mq.size() > 0) || bn));
        if (!bn) begin
            chk("enc",   q_enc,             last.enc);
            chk("class", 32'(q_class),      32'(last.cls));
            chk("sub",   32'(q_subclass),   32'(last.sub));
            chk("pw",    32'(q_pw),         32'(last.pw));
            chk("exc",   32'(q_exc),        32'(last.exc));
            chk("tag",   32'(q_tag),        last.tag);
        end
    endtask

    // One clock cycle with the inputs already driven (called at a negedge).
    task automatic cycle();
        logic exp_ack, push, pop, byp;
        ent_t in_e;
        #1;
        exp_ack = (mq.size() < DEPTH) && !flush;
        chk("ack", 32'(cpu_insn_ack), 32'(exp_ack));
        in_e = '{cpu_insn_enc, dec_class, dec_subclass, dec_pw,
                 ref_exc(dec_exception, dec_class, dec_subclass, dec_pw, mccr), m_tag};
        push = cpu_insn_req && exp_ack;
        byp  = push && byp_now();
        if (byp) begin
            chk("byp_valid", 32'(q_valid),   32'd1);
            chk("byp_enc",   q_enc,          in_e.enc);
            chk("byp_exc",   32'(q_exc),     32'(in_e.exc));
            chk("byp_tag",   32'(q_tag),     in_e.tag);
            chk("byp_level", 32'(q_level),   32'd0);
        end
        pop = (mq.size() > 0) && q_ready && !flush;
        @(posedge g_clk);
        if (flush) begin
            $display("[TB] flush discards %0d entries", mq.size());
            mq.delete();
        end else begin
            if (pop) begin
                $display("[TB] pop  tag=%0d exc=%0d", mq[0].tag, mq[0].exc);
                void'(mq.pop_front());
            end
            if (push && !byp) mq.push_back(in_e);
        end
        if (push) begin
            $display("[TB] push tag=%0d cls=%0d exc=%0d%s", in_e.tag, in_e.cls,
                     in_e.exc, byp ? " (bypass)" : "");
            m_tag = (m_tag + 1) % (1 << TAG_W);
        end
        if (byp) last = in_e;
        else if (mq.size() > 0) last = mq[0];
        @(negedge g_clk);
        check_state();
    endtask

    task automatic do_reset();
        set_in(1'b0, 4'd0, 5'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        g_resetn = 1'b0;
        #1;
        mq.delete();
        m_tag = 0;
        last  = '{32'h0, 4'h0, 5'h0, 3'h0, 2'h0, 0};
        chk("rst_valid", 32'(q_valid),      32'd0);
        chk("rst_level", 32'(q_level),      32'd0);
        chk("rst_ack",   32'(cpu_insn_ack), 32'd0);
        chk("rst_enc",   q_enc,             32'd0);
        chk("rst_exc",   32'(q_exc),        32'd0);
        chk("rst_tag",   32'(q_tag),        32'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
        check_state();
        $display("[TB] reset done");
    endtask

    initial begin
        do_reset();

        // Fill to DEPTH with the execute stage stalled.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0);
            cycle();
        end
        chk("full_level", 32'(q_level), 32'd4);
        chk("full_head_tag", 32'(q_tag), 32'd0);

        // Full with req and ready: pop only.
        set_in(1'b1, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0);
        cycle();
        chk("after_full_pop_level", 32'(q_level), 32'd3);
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0);
        cycle();

        // Drain; head tags are checked in order by the model.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0);
            cycle();
        end

        // RANDOM class with R disabled / enabled / decode exception.
        set_in(1'b1, C_RANDOM, 5'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0); cycle();
        chk("rnd_disabled_exc", 32'(q_exc), 32'd2);
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0); cycle();
        set_in(1'b1, C_RANDOM, 5'd0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0); cycle();
        chk("rnd_enabled_exc", 32'(q_exc), 32'd0);
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0); cycle();
        set_in(1'b1, C_RANDOM, 5'd0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0); cycle();
        chk("illegal_exc", 32'(q_exc), 32'd1);
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0); cycle();

        // PACKED_ARITH PW_16 gated by P2.
        set_in(1'b1, C_PACKED, 5'd0, PW16, 1'b0, 8'h7F, 1'b0, 1'b0); cycle();
        chk("pw16_disabled_exc", 32'(q_exc), 32'd2);
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0); cycle();
        set_in(1'b1, C_PACKED, 5'd0, PW16, 1'b0, 8'h80, 1'b0, 1'b0); cycle();
        chk("pw16_enabled_exc", 32'(q_exc), 32'd0);
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0); cycle();

        // Flush with 3 queued and req high.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b1, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b1);
        #1;
        chk("flush_ack", 32'(cpu_insn_ack), 32'd0);
        cycle();
        chk("flush_level", 32'(q_level), 32'd0);
        chk("flush_valid", 32'(q_valid), 32'd0);
        set_in(1'b1, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0); cycle();
        chk("flush_next_tag", 32'(q_tag), 32'd3);

        // Tag wrap: 17 pushes from reset, the 17th carries tag 0.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0);
            cycle();
        end
        set_in(1'b0, C_MOVE, 5'd0, 3'd0, 1'b0, 8'hFF, 1'b0, 1'b0);
        #1;
        chk("wrap_tag", 32'(q_tag), 32'd0);
        @(negedge g_clk);

        // Reset in the middle of operation.
        set_in(1'b1, C_MP, 5'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0); cycle();
        set_in(1'b1, C_MP, 5'd0, 3'd0, 1'b0, 8'h02, 1'b0, 1'b0); cycle();
        do_reset();
        set_in(1'b1, C_LOADSTORE, 5'd2, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0); cycle();
        chk("post_reset_tag", 32'(q_tag), 32'd0);
        chk("sg_disabled_exc", 32'(q_exc), 32'd2);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0,
                   4'($urandom_range(0, 8)),
                   5'($urandom_range(0, 7)),
                   3'($urandom_range(0, 6)),
                   $urandom_range(0, 7) == 0,
                   8'($urandom),
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
